shfifo_burst_reader: RTL and testbench



---
 rtl/shfifo_pkg.sv | 25 ++
 rtl/shfifo_rd_oreg.sv | 39 +++
 rtl/shfifo_burst_reader.sv | 150 +++++++++++++++
 tb/tb_shfifo_burst_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shfifo_pkg.sv
// Shared types and helpers for the show-ahead FIFO burst reader.
package shfifo_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam int FIFO_ADDR_DEF = 3;
    localparam int CNT_W         = FIFO_ADDR_DEF + 1;

    // A zero request still moves one beat; anything past the FIFO depth is capped at the depth.
    function automatic logic [31:0] eff_len_f(input logic [31:0] len, input logic [31:0] max_len);
        logic [31:0] res_s;
        if (len == 32'd0) begin
            res_s = 32'd1;
        end else if (len > max_len) begin
            res_s = max_len;
        end else begin
            res_s = len;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/shfifo_rd_oreg.sv
// Single-entry output register of the burst reader: load on pop, hold while stalled,
// clear once the beat is taken with nothing new behind it.
module shfifo_rd_oreg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] in_dat,
    input  logic         in_sof,
    input  logic         in_eof,
    input  logic         m_rdy,
    output logic         m_vld,
    output logic [W-1:0] m_dat,
    output logic         m_sof,
    output logic         m_eof,
    output logic         can_load
);

    assign can_load = ~m_vld | m_rdy;

    // Output beat storage
    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld <= 1'b0;
            m_dat <= {W{1'b0}};
            m_sof <= 1'b0;
            m_eof <= 1'b0;
        end else if (load) begin
            m_vld <= 1'b1;
            m_dat <= in_dat;
            m_sof <= in_sof;
            m_eof <= in_eof;
        end else if (m_vld && m_rdy) begin
            m_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/shfifo_burst_reader.sv
// Drains a show-ahead FIFO in whole bursts onto a valid/ready stream with sof/eof.
// Optional idle-timeout partial flush: SHFIFO_BURST_RD_TIMEOUT_EN.
module shfifo_burst_reader
    import shfifo_pkg::*;
#(
    parameter int FIFO_WIDTH  = 32,
    parameter int FIFO_ADDR   = 3,
    parameter int TIMEOUT_CYC = 64,
    parameter int TMO_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_ADDR:0]    burst_len,
    output logic                  fifo_ren,
    input  logic [FIFO_WIDTH-1:0] fifo_rdat,
    input  logic                  fifo_empty,
    input  logic [FIFO_ADDR:0]    fifo_rcnt,
    output logic                  m_vld,
    input  logic                  m_rdy,
    output logic [FIFO_WIDTH-1:0] m_dat,
    output logic                  m_sof,
    output logic                  m_eof,
    output logic                  busy,
    output logic                  rd_underflow_err
);

    localparam int          LEN_W   = FIFO_ADDR + 1;
    localparam logic [31:0] MAX_LEN = 32'd1 << FIFO_ADDR;

    if (TIMEOUT_CYC >= (1 << TMO_W)) begin : g_tmo_cfg_bad
        $error("TIMEOUT_CYC must be below 2**TMO_W");
    end

    state_e             state_r, state_nxt_s;
    logic [LEN_W-1:0]   beat_cnt_r, beat_cnt_nxt_s;
    logic               sof_pend_r, sof_pend_nxt_s;
    logic               err_r;
    logic [LEN_W-1:0]   eff_len_s;
    logic               can_load_s;
    logic               pop_s;
    logic               start_full_s;
    logic               start_tmo_s;

    assign eff_len_s    = LEN_W'(eff_len_f(32'(burst_len), MAX_LEN));
    assign start_full_s = (state_r == ST_IDLE) && (fifo_rcnt >= eff_len_s);
    // No pop while in reset so an aborted burst leaves the FIFO contents alone.
    assign pop_s        = ~rst && (state_r == ST_BURST) && can_load_s && (beat_cnt_r != {LEN_W{1'b0}});

`ifdef SHFIFO_BURST_RD_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_cnt_r;

    assign start_tmo_s = (state_r == ST_IDLE) && (fifo_rcnt != {LEN_W{1'b0}}) && (tmo_cnt_r == TMO_LAST);

    // Idle timeout counter: runs only while idle with a partial fill
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_r == ST_IDLE) && (fifo_rcnt != {LEN_W{1'b0}}) && !start_full_s && !start_tmo_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end
`else
    assign start_tmo_s = 1'b0;
`endif

    // Burst sequencing: start condition, beat countdown, pending sof
    always_comb begin
        state_nxt_s    = state_r;
        beat_cnt_nxt_s = beat_cnt_r;
        sof_pend_nxt_s = sof_pend_r;
        case (state_r)
            ST_IDLE: begin
                if (start_full_s) begin
                    state_nxt_s    = ST_BURST;
                    beat_cnt_nxt_s = eff_len_s;
                    sof_pend_nxt_s = 1'b1;
                end else if (start_tmo_s) begin
                    state_nxt_s    = ST_BURST;
                    beat_cnt_nxt_s = fifo_rcnt;
                    sof_pend_nxt_s = 1'b1;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (pop_s) begin
                    beat_cnt_nxt_s = beat_cnt_r - LEN_W'(1);
                    sof_pend_nxt_s = 1'b0;
                    if (beat_cnt_r == LEN_W'(1)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_BURST;
                    end
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                beat_cnt_nxt_s = {LEN_W{1'b0}};
                sof_pend_nxt_s = 1'b0;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            beat_cnt_r <= {LEN_W{1'b0}};
            sof_pend_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
            sof_pend_r <= sof_pend_nxt_s;
        end
    end

    // Sticky underflow flag: a pop issued against an empty FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (pop_s && fifo_empty) begin
            err_r <= 1'b1;
        end
    end

    shfifo_rd_oreg #(.W(FIFO_WIDTH)) u_oreg (
        .clk      (clk),
        .rst      (rst),
        .load     (pop_s),
        .in_dat   (fifo_rdat),
        .in_sof   (sof_pend_r),
        .in_eof   (beat_cnt_r == LEN_W'(1)),
        .m_rdy    (m_rdy),
        .m_vld    (m_vld),
        .m_dat    (m_dat),
        .m_sof    (m_sof),
        .m_eof    (m_eof),
        .can_load (can_load_s)
    );

    assign fifo_ren         = pop_s;
    assign busy             = (state_r == ST_BURST) || m_vld;
    assign rd_underflow_err = err_r;

endmodule

// File: tb/tb_shfifo_burst_reader.sv
// Self-checking bench: show-ahead FIFO stand-in, burst-level reference model, table and random tests.
module tb_shfifo_burst_reader;
    import shfifo_pkg::*;

    localparam int W     = 32;
    localparam int A     = FIFO_ADDR_DEF;
    localparam int DEPTH = 1 << A;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] burst_len;
    logic             fifo_ren;
    logic [W-1:0]     fifo_rdat;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_rcnt;
    logic             m_vld, m_rdy, m_sof, m_eof, busy, rd_underflow_err;
    logic [W-1:0]     m_dat;

    always #5 clk = ~clk;

    shfifo_burst_reader #(.FIFO_WIDTH(W), .FIFO_ADDR(A), .TIMEOUT_CYC(64), .TMO_W(8)) dut (
        .clk(clk), .rst(rst), .burst_len(burst_len), .fifo_ren(fifo_ren), .fifo_rdat(fifo_rdat),
        .fifo_empty(fifo_empty), .fifo_rcnt(fifo_rcnt), .m_vld(m_vld), .m_rdy(m_rdy), .m_dat(m_dat),
        .m_sof(m_sof), .m_eof(m_eof), .busy(busy), .rd_underflow_err(rd_underflow_err)
    );

    // FIFO stand-in (not reset by rst)
    logic [W-1:0]     mem [DEPTH];
    int               wp = 0, rp = 0, cnt = 0;
    logic             wr_en = 1'b0;
    logic [W-1:0]     wr_dat = '0;
    logic             ovr_en = 1'b0;
    logic [CNT_W-1:0] ovr_cnt = '0;

    always @(posedge clk) begin
        if (wr_en && cnt < DEPTH) begin
            mem[wp] <= wr_dat;
            wp <= (wp + 1) % DEPTH;
        end
        if (fifo_ren && cnt != 0) rp <= (rp + 1) % DEPTH;
        cnt <= cnt + ((wr_en && cnt < DEPTH) ? 1 : 0) - ((fifo_ren && cnt != 0) ? 1 : 0);
    end
    assign fifo_empty = (cnt == 0);
    assign fifo_rdat  = fifo_empty ? '0 : mem[rp];
    assign fifo_rcnt  = ovr_en ? ovr_cnt : CNT_W'(cnt);

    int n_chk = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: words stream out in write order, cut into bursts of the clamped length
    typedef struct packed {logic [W-1:0] d; logic sof; logic eof;} beat_t;
    beat_t        exp_q[$];
    logic [W-1:0] pend_q[$];
    int           cur_len = 4;
    bit           sb_en = 1'b1;

    function automatic int eff(input int l);
        return (l == 0) ? 1 : ((l > DEPTH) ? DEPTH : l);
    endfunction

    task automatic emit(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = pend_q.pop_front(); b.sof = (i == 0); b.eof = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic form();
        while (pend_q.size() >= eff(cur_len)) emit(eff(cur_len));
    endtask

    task automatic set_len(input int l);
        burst_len = CNT_W'(l); cur_len = l; form();
    endtask

    task automatic push_n(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_dat = base + W'(i);
            pend_q.push_back(base + W'(i)); form();
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #3;
            if (exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
        end
        chk({name, "_drain"}, ok, 1'b1);
    endtask

    // Monitor: scoreboard taken beats and require stalled beats to hold
    int    acc_cnt = 0;
    bit    hold_pend = 1'b0;
    beat_t held, mon_b;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) chk("stall_hold", {m_vld, m_dat, m_sof, m_eof}, {1'b1, held});
            hold_pend = 1'b0;
            if (m_vld && m_rdy) begin
                acc_cnt++;
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL unexpected_beat: got data %0h sof %0b eof %0b, expected no beat", m_dat, m_sof, m_eof);
                    end else begin
                        mon_b = exp_q.pop_front();
                        chk("beat", {m_dat, m_sof, m_eof}, mon_b);
                    end
                end
            end else if (m_vld) begin
                hold_pend = 1'b1; held = {m_dat, m_sof, m_eof};
            end
        end
    end

    typedef struct {int len; int nwords; int exp_beats;} vec_t;
    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int a0, first, last, nb, k, l, need;
        bit ok, done;
        logic [3:0] rdy_pat;

        vecs = '{'{0, 1, 1}, '{1, 3, 3}, '{2, 4, 4}, '{3, 3, 3}, '{8, 8, 8},
                 '{12, 8, 8}, '{15, 8, 8}, '{5, 3, 0}, '{6, 7, 6}};
        rst = 1'b1; burst_len = 4'd4; m_rdy = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", m_vld, 1'b0); chk("rst_dat", m_dat, 32'd0); chk("rst_sof", m_sof, 1'b0);
        chk("rst_eof", m_eof, 1'b0); chk("rst_busy", busy, 1'b0); chk("rst_ren", fifo_ren, 1'b0);
        chk("rst_err", rd_underflow_err, 1'b0);
        @(negedge clk); rst = 1'b0;

        // Four-word burst at full rate
        set_len(4);
        push_n(4, 32'hA000_0000);
        first = -1; last = -1; nb = 0; done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            if (m_vld && m_rdy) begin
                if (first < 0) first = i;
                last = i; nb++;
            end else if (nb > 0 && !done) begin
                chk("t1_busy_after", busy, 1'b0); chk("t1_rcnt", fifo_rcnt, 4'd0); done = 1'b1;
            end
        end
        chk("t1_nbeats", nb, 4); chk("t1_back_to_back", last - first, 3);

`ifndef SHFIFO_BURST_RD_TIMEOUT_EN
        // Partial fill never starts a burst without the timeout feature
        push_n(3, 32'hB000_0000);
        nb = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #3;
            if (m_vld) nb++;
        end
        chk("t2_no_partial", nb, 0);
        @(negedge clk);
        wr_en = 1'b1; wr_dat = 32'hB000_0003; pend_q.push_back(32'hB000_0003); form();
        @(posedge clk); #1; wr_en = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; k++;
            if (m_vld) break;
        end
        chk("t2_start_latency", k, 2);
        wait_drain("t2");
`else
        // Partial fill flushed after the idle timeout
        set_len(4);
        @(negedge clk);
        wr_en = 1'b1; wr_dat = 32'hC000_0000; pend_q.push_back(32'hC000_0000);
        @(posedge clk); #1; wr_dat = 32'hC000_0001; pend_q.push_back(32'hC000_0001);
        @(posedge clk); #1; wr_en = 1'b0;
        k = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1; k++;
            if (busy) break;
        end
        emit(pend_q.size());
        chk("t3_tmo_cycles", k, 64);
        wait_drain("t3");
`endif

        // Stalled drain of a full FIFO
        set_len(8); m_rdy = 1'b0;
        push_n(8, 32'hD000_0000);
        rdy_pat = 4'b1001; a0 = acc_cnt;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); m_rdy = rdy_pat[i % 4];
        end
        chk("t4_accepted", acc_cnt - a0, 8);
        @(negedge clk); m_rdy = 1'b1;
        wait_drain("t4");

        // Reset in the middle of a burst
        set_len(4); m_rdy = 1'b0;
        push_n(4, 32'hE000_0000);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            if (m_vld) begin ok = 1'b1; break; end
        end
        chk("t5_first_vld", ok, 1'b1);
        @(negedge clk); m_rdy = 1'b1;
        @(negedge clk); m_rdy = 1'b0; rst = 1'b1;
        exp_q.delete(); pend_q.delete();
        pend_q.push_back(32'hE000_0002); pend_q.push_back(32'hE000_0003);
        @(negedge clk); rst = 1'b0; #3;
        chk("t5_vld", m_vld, 1'b0); chk("t5_busy", busy, 1'b0);
        chk("t5_state", dut.state_r, ST_IDLE); chk("t5_rcnt", fifo_rcnt, 4'd2);
        repeat (5) @(negedge clk);
        #3;
        chk("t5_still_idle", busy, 1'b0); chk("t5_rcnt_kept", fifo_rcnt, 4'd2);
        m_rdy = 1'b1;
        push_n(2, 32'hE000_0004);
        wait_drain("t5");

        // Table of lengths, including 0 and values past the depth
        foreach (vecs[i]) begin
            @(negedge clk); set_len(vecs[i].len); m_rdy = 1'b1;
            a0 = acc_cnt;
            push_n(vecs[i].nwords, 32'h1000_0000 * (i + 1));
            repeat (30) @(negedge clk);
            chk($sformatf("vec%0d_beats", i), acc_cnt - a0, vecs[i].exp_beats);
            set_len(1);
            wait_drain($sformatf("vec%0d", i));
        end

        // Randomized traffic against the reference model
        for (int ph = 0; ph < 4; ph++) begin
            l = (ph == 3) ? 11 : $urandom_range(1, 8);
            @(negedge clk); set_len(l);
            for (int c = 0; c < 250; c++) begin
                @(negedge clk);
                m_rdy = ($urandom_range(0, 3) != 0);
                if (cnt < DEPTH && $urandom_range(0, 1) == 1) begin
                    wr_en = 1'b1; wr_dat = $urandom;
                    pend_q.push_back(wr_dat); form();
                end else begin
                    wr_en = 1'b0;
                end
            end
            @(negedge clk); wr_en = 1'b0; m_rdy = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk); #3;
                if (!busy && fifo_rcnt < eff(l)) begin ok = 1'b1; break; end
            end
            chk($sformatf("rnd%0d_idle", ph), ok, 1'b1);
            need = (pend_q.size() > 0) ? eff(l) - pend_q.size() : 0;
            push_n(need, 32'h5500_0000 + 32'(ph << 8));
            wait_drain($sformatf("rnd%0d", ph));
        end
        chk("no_err_so_far", rd_underflow_err, 1'b0);

        // Underflow: occupancy claims a word the FIFO does not have
        sb_en = 1'b0;
        @(negedge clk); set_len(1); ovr_en = 1'b1; ovr_cnt = 4'd1;
        @(negedge clk); ovr_en = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("uf_set", rd_underflow_err, 1'b1);
        repeat (5) @(negedge clk);
        #3;
        chk("uf_sticky", rd_underflow_err, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #3;
        chk("uf_cleared", rd_underflow_err, 1'b0);
        sb_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
